cmp_share_arbiter: RTL and testbench

- Shares one 32-bit set-less-than comparator (SLT/SLTI/SLTU/SLTIU semantics) between NUM_REQ requesters, e.g. multiple issue slots or a branch-resolve helper.
- Arbitration is round-robin. Each requester has a valid/ready handshake.
- The block computes the result of the winning request and holds it in a single registered response stage with backpressure. The response carries the winner's index and tag.
- The block sits between the issue logic and the writeback mux.

---
 rtl/cmp_share_arbiter.sv | 129 ++++++++++++
 tb/tb_cmp_share_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one SLT/SLTU comparator between requesters.
// One registered response stage with backpressure; 1-cycle latency.
module cmp_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*32-1:0]    req_a,
    input  logic [NUM_REQ*32-1:0]    req_b,
    input  logic [NUM_REQ*7-1:0]     req_opcode,
    input  logic [NUM_REQ*3-1:0]     req_func3,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_result,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_illegal
);

    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              rsp_illegal_q, rsp_illegal_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              found;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   cand;
    logic              can_accept;
    logic              accept;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic [6:0]        sel_op;
    logic [2:0]        sel_f3;
    logic              op_ok;
    logic              legal;
    logic              lt;

    // Scan from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    assign sel_a  = req_a[32*int'(win_id) +: 32];
    assign sel_b  = req_b[32*int'(win_id) +: 32];
    assign sel_op = req_opcode[7*int'(win_id) +: 7];
    assign sel_f3 = req_func3[3*int'(win_id) +: 3];

    assign op_ok = (sel_op == 7'b0110011) || (sel_op == 7'b0010011);
    assign legal = op_ok && ((sel_f3 == 3'b010) || (sel_f3 == 3'b011));

    always_comb begin
        lt = 1'b0;
        if (legal && sel_f3 == 3'b010) begin
            lt = $signed(sel_a) < $signed(sel_b);
        end else if (legal) begin
            lt = sel_a < sel_b;
        end
    end

    assign can_accept = !rsp_valid_q || rsp_ready;
    assign accept     = can_accept && found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_id_d      = rsp_id_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_illegal_d = rsp_illegal_q;
        rr_ptr_d      = rr_ptr_q;
        if (accept) begin
            rsp_valid_d   = 1'b1;
            rsp_result_d  = {31'b0, lt};
            rsp_id_d      = win_id;
            rsp_tag_d     = req_tag[TAG_W*int'(win_id) +: TAG_W];
            rsp_illegal_d = !legal;
            rr_ptr_d      = ID_W'((int'(win_id) + 1) % NUM_REQ);
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_id_q      <= '0;
            rsp_tag_q     <= '0;
            rsp_illegal_q <= 1'b0;
            rr_ptr_q      <= '0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_id_q      <= rsp_id_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_illegal_q <= rsp_illegal_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: directed scenarios then random traffic
// checked against a behavioural model of arbitration and compare.
module tb_cmp_share_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int IW = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N*7-1:0]    req_opcode;
    logic [N*3-1:0]    req_func3;
    logic [N*TW-1:0]   req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic [IW-1:0]     rsp_id;
    logic [TW-1:0]     rsp_tag;
    logic              rsp_illegal;

    cmp_share_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_opcode (req_opcode),
        .req_func3  (req_func3),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_illegal(rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the response register and pointer should hold.
    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_result;
    int          m_id;
    logic [TW-1:0] m_tag;
    bit          m_ill;

    int waits [N];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_ref(input logic [6:0] op, input logic [2:0] f3);
        return (op == 7'h33 || op == 7'h13) && (f3 == 3'd2 || f3 == 3'd3);
    endfunction

    function automatic logic cmp_ref(input logic [31:0] a, input logic [31:0] b,
                                     input logic [6:0] op, input logic [2:0] f3);
        if (!legal_ref(op, f3)) return 1'b0;
        if (f3 == 3'd2) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    function automatic int winner_ref();
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_result = 0;
        m_id = 0; m_tag = 0; m_ill = 0;
    endtask

    task automatic set_req(input int i, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [6:0] op,
                           input logic [2:0] f3, input logic [TW-1:0] tg);
        req_valid[i]          = v;
        req_a[i*32 +: 32]     = a;
        req_b[i*32 +: 32]     = b;
        req_opcode[i*7 +: 7]  = op;
        req_func3[i*3 +: 3]   = f3;
        req_tag[i*TW +: TW]   = tg;
    endtask

    // One clock: check grant, advance model at the edge, check response.
    task automatic step(output int acc);
        int w;
        bit can;
        logic [N-1:0] er;
        #1;
        w   = winner_ref();
        can = !m_valid || rsp_ready;
        er  = '0;
        acc = -1;
        if (can && w >= 0) begin
            er[w] = 1'b1;
            acc   = w;
        end
        check("req_ready", 64'(req_ready), 64'(er));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            acc = -1;
        end else if (acc >= 0) begin
            m_valid  = 1;
            m_result = {31'b0, cmp_ref(req_a[w*32 +: 32], req_b[w*32 +: 32],
                                       req_opcode[w*7 +: 7], req_func3[w*3 +: 3])};
            m_id     = w;
            m_tag    = req_tag[w*TW +: TW];
            m_ill    = !legal_ref(req_opcode[w*7 +: 7], req_func3[w*3 +: 3]);
            m_ptr    = (w + 1) % N;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("rsp_result", 64'(rsp_result), 64'(m_result));
        check("rsp_id", 64'(rsp_id), 64'(m_id));
        check("rsp_tag", 64'(rsp_tag), 64'(m_tag));
        check("rsp_illegal", 64'(rsp_illegal), 64'(m_ill));
        @(negedge clk);
    endtask

    logic [31:0] t2_a  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd20, 32'd2};
    logic [31:0] t2_b  [4] = '{32'd10, 32'd10, 32'hFFFFFFFF, 32'd10};
    logic [6:0]  t2_op [4] = '{7'h33, 7'h33, 7'h13, 7'h13};
    logic [2:0]  t2_f3 [4] = '{3'd3, 3'd2, 3'd2, 3'd3};
    logic [31:0] t2_exp[4] = '{32'd0, 32'd1, 32'd0, 32'd1};

    initial begin
        int acc;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [6:0]  rop;
        logic [2:0]  rf3;

        rst_n = 0; rsp_ready = 0;
        req_valid = '0; req_a = '0; req_b = '0;
        req_opcode = '0; req_func3 = '0; req_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check("reset_valid", 64'(rsp_valid), 64'(0));
        check("reset_result", 64'(rsp_result), 64'(0));
        check("reset_id", 64'(rsp_id), 64'(0));
        check("reset_tag", 64'(rsp_tag), 64'(0));
        check("reset_illegal", 64'(rsp_illegal), 64'(0));
        rst_n = 1;

        // Signed SLT of -5 < 10
        rsp_ready = 1;
        set_req(0, 1, 32'hFFFFFFFB, 32'd10, 7'h33, 3'd2, 4'd3);
        step(acc);
        check("t1_acc", 64'(acc), 64'(0));
        check("t1_result", 64'(rsp_result), 64'(1));
        check("t1_id", 64'(rsp_id), 64'(0));
        check("t1_tag", 64'(rsp_tag), 64'(3));
        check("t1_illegal", 64'(rsp_illegal), 64'(0));
        req_valid[0] = 0;

        for (int i = 0; i < 4; i++) begin
            set_req(1, 1, t2_a[i], t2_b[i], t2_op[i], t2_f3[i], 4'(i));
            step(acc);
            check("t2_result", 64'(rsp_result), 64'(t2_exp[i]));
            req_valid[1] = 0;
        end

        // Round-robin from a fresh pointer with all requesters busy
        rst_n = 0;
        step(acc);
        rst_n = 1;
        for (int i = 0; i < N; i++)
            set_req(i, 1, 32'(i), 32'd2, 7'h33, 3'd3, 4'(i + 8));
        for (int k = 0; k < 5; k++) begin
            step(acc);
            check("t3_id", 64'(rsp_id), 64'(k % N));
            check("t3_valid", 64'(rsp_valid), 64'(1));
        end
        req_valid = '0;

        // Backpressure
        set_req(1, 1, 32'd5, 32'd6, 7'h33, 3'd2, 4'd7);
        step(acc);
        req_valid[1] = 0;
        rsp_ready = 0;
        set_req(2, 1, 32'd9, 32'd3, 7'h13, 3'd3, 4'd5);
        for (int k = 0; k < 3; k++) begin
            step(acc);
            check("t4_ready", 64'(req_ready), 64'(0));
            check("t4_hold_id", 64'(rsp_id), 64'(1));
            check("t4_hold_res", 64'(rsp_result), 64'(1));
        end
        rsp_ready = 1;
        step(acc);
        check("t4_id", 64'(rsp_id), 64'(2));
        check("t4_tag", 64'(rsp_tag), 64'(5));
        req_valid[2] = 0;

        // Illegal combinations
        set_req(0, 1, 32'd1, 32'd2, 7'h33, 3'd0, 4'd1);
        step(acc);
        check("t5a_result", 64'(rsp_result), 64'(0));
        check("t5a_illegal", 64'(rsp_illegal), 64'(1));
        set_req(0, 1, 32'hFFFFFFFF, 32'd2, 7'h03, 3'd2, 4'd2);
        step(acc);
        check("t5b_result", 64'(rsp_result), 64'(0));
        check("t5b_illegal", 64'(rsp_illegal), 64'(1));
        req_valid[0] = 0;

        // Reset with a pending response
        rsp_ready = 0;
        set_req(3, 1, 32'd1, 32'd7, 7'h33, 3'd3, 4'd9);
        rst_n = 0;
        step(acc);
        check("t6_valid", 64'(rsp_valid), 64'(0));
        check("t6_tag", 64'(rsp_tag), 64'(0));
        rst_n = 1;
        rsp_ready = 1;
        set_req(0, 1, 32'd4, 32'd4, 7'h33, 3'd2, 4'd4);
        step(acc);
        check("t6_id", 64'(rsp_id), 64'(0));
        req_valid = '0;
        step(acc);

        // Random traffic with hold-until-accepted requesters
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    ra = $urandom;
                    rb = ($urandom_range(3, 0) == 0) ? ra : $urandom;
                    if ($urandom_range(3, 0) == 0) begin
                        ra = 32'($urandom_range(3, 0));
                        rb = 32'($urandom_range(3, 0));
                    end
                    case ($urandom_range(3, 0))
                        0, 1: rop = 7'h33;
                        2: rop = 7'h13;
                        default: rop = 7'($urandom);
                    endcase
                    rf3 = ($urandom_range(3, 0) == 0) ? 3'($urandom)
                                                      : 3'($urandom_range(3, 2));
                    set_req(i, 1, ra, rb, rop, rf3, 4'($urandom));
                end
            end
            rsp_ready = ($urandom_range(3, 0) != 0);
            rst_n = ($urandom_range(199, 0) != 0);
            step(acc);
            if (!rst_n) begin
                for (int i = 0; i < N; i++) waits[i] = 0;
            end
            if (acc >= 0) begin
                for (int i = 0; i < N; i++)
                    if (i != acc && req_valid[i]) waits[i]++;
                check("fairness", 64'(waits[acc] < N), 64'(1));
                waits[acc] = 0;
                req_valid[acc] = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
